// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one SRAM port between alpha blend (1) and fill (2).
// Each access holds the enables for SRAM_LAT cycles, then pulses done to the owner.
module sram_arbiter #(
  parameter int ADDR_W   = 19,
  parameter int DATA_W   = 1536,
  parameter int SRAM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req1,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              done1,
  input  logic              req2,
  input  logic              wr2,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [DATA_W-1:0] wdata2,
  output logic              gnt2,
  output logic              done2,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              sram_read_enable,
  output logic              sram_write_enable,
  output logic [ADDR_W-1:0] sram_address,
  output logic [DATA_W-1:0] sram_write_data,
  input  logic [DATA_W-1:0] sram_read_data
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(SRAM_LAT - 1);

  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic last2, last2_n;
  logic owner2, owner2_n;
  logic wr_q, wr_q_n;
  logic sel2;

  logic gnt1_n, gnt2_n, done1_n, done2_n, busy_n;
  logic ren_n, wen_n;
  logic [ADDR_W-1:0] addr_n;
  logic [DATA_W-1:0] wdata_n;
  logic [DATA_W-1:0] rdata_n;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    last2_n  = last2;
    owner2_n = owner2;
    wr_q_n   = wr_q;
    sel2     = 1'b0;
    gnt1_n   = 1'b0;
    gnt2_n   = 1'b0;
    done1_n  = 1'b0;
    done2_n  = 1'b0;
    busy_n   = busy;
    ren_n    = sram_read_enable;
    wen_n    = sram_write_enable;
    addr_n   = sram_address;
    wdata_n  = sram_write_data;
    rdata_n  = rdata;
    unique case (state)
      IDLE: begin
        if (req1 || req2) begin
          // on a tie, the requester not granted last wins
          sel2     = req2 && (!req1 || !last2);
          owner2_n = sel2;
          last2_n  = sel2;
          wr_q_n   = sel2 ? wr2 : wr1;
          addr_n   = sel2 ? addr2 : addr1;
          wdata_n  = sel2 ? wdata2 : wdata1;
          cnt_n    = CNT_INIT;
          gnt1_n   = !sel2;
          gnt2_n   = sel2;
          ren_n    = sel2 ? !wr2 : !wr1;
          wen_n    = sel2 ? wr2 : wr1;
          busy_n   = 1'b1;
          state_n  = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt == 4'd0) begin
          ren_n   = 1'b0;
          wen_n   = 1'b0;
          done1_n = !owner2;
          done2_n = owner2;
          if (!wr_q) rdata_n = sram_read_data;
          state_n = DONE;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      DONE: begin
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: begin
        busy_n  = 1'b0;
        ren_n   = 1'b0;
        wen_n   = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      cnt               <= 4'd0;
      last2             <= 1'b1;
      owner2            <= 1'b0;
      wr_q              <= 1'b0;
      gnt1              <= 1'b0;
      gnt2              <= 1'b0;
      done1             <= 1'b0;
      done2             <= 1'b0;
      busy              <= 1'b0;
      sram_read_enable  <= 1'b0;
      sram_write_enable <= 1'b0;
      sram_address      <= '0;
      sram_write_data   <= '0;
      rdata             <= '0;
    end else begin
      state             <= state_n;
      cnt               <= cnt_n;
      last2             <= last2_n;
      owner2            <= owner2_n;
      wr_q              <= wr_q_n;
      gnt1              <= gnt1_n;
      gnt2              <= gnt2_n;
      done1             <= done1_n;
      done2             <= done2_n;
      busy              <= busy_n;
      sram_read_enable  <= ren_n;
      sram_write_enable <= wen_n;
      sram_address      <= addr_n;
      sram_write_data   <= wdata_n;
      rdata             <= rdata_n;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with SRAM_LAT=2 and a narrow data word.
// Expected values are hand-derived cycle by cycle from the request timing.
module tb_sram_arbiter;

  localparam int AW = 19;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          req1, wr1, req2, wr2;
  logic [AW-1:0] addr1, addr2;
  logic [DW-1:0] wdata1, wdata2;
  logic          gnt1, done1, gnt2, done2, busy;
  logic [DW-1:0] rdata;
  logic          ren, wen;
  logic [AW-1:0] saddr;
  logic [DW-1:0] swdata, srdata;

  int total = 0;
  int bad   = 0;

  sram_arbiter #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .SRAM_LAT(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req1(req1),
    .wr1(wr1),
    .addr1(addr1),
    .wdata1(wdata1),
    .gnt1(gnt1),
    .done1(done1),
    .req2(req2),
    .wr2(wr2),
    .addr2(addr2),
    .wdata2(wdata2),
    .gnt2(gnt2),
    .done2(done2),
    .rdata(rdata),
    .busy(busy),
    .sram_read_enable(ren),
    .sram_write_enable(wen),
    .sram_address(saddr),
    .sram_write_data(swdata),
    .sram_read_data(srdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] got,
                     input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req1 = 1'b0;
    req2 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  always @(negedge clk)
    if (!rst) chk("excl_en", DW'(ren & wen), '0);

  int g1_seen;
  int d2_seen;

  initial begin
    wr1 = 1'b0;
    wr2 = 1'b0;
    addr1 = '0;
    addr2 = '0;
    wdata1 = '0;
    wdata2 = '0;
    srdata = '0;
    do_reset();
    chk("rst_outs", DW'({gnt1, gnt2, done1, done2, busy, ren, wen}), '0);
    chk("rst_addr", DW'(saddr), '0);
    chk("rst_rdata", rdata, '0);

    // 1: single read by requester 1
    req1 = 1'b1;
    addr1 = 19'h12345;
    srdata = 64'h1111;
    tick();
    req1 = 1'b0;
    addr1 = '0;
    chk("t1_gnt1", DW'({gnt1, gnt2, ren, wen, busy}), DW'(5'b10101));
    chk("t1_addr", DW'(saddr), DW'(19'h12345));
    srdata = 64'h2222;
    tick();
    chk("t1_acc2", DW'({gnt1, ren, wen, done1}), DW'(4'b0100));
    srdata = 64'hBEEF;
    tick();
    chk("t1_done", DW'({done1, done2, ren, wen, busy}), DW'(5'b10001));
    chk("t1_rdata", rdata, 64'hBEEF);
    srdata = 64'h0;
    tick();
    chk("t1_idle", DW'({done1, busy}), '0);
    chk("t1_hold", rdata, 64'hBEEF);

    // 2: tie after reset, req1 dropped on done1
    do_reset();
    req1 = 1'b1;
    req2 = 1'b1;
    tick();
    chk("t2_g1", DW'({gnt1, gnt2}), DW'(2'b10));
    tick();
    tick();
    chk("t2_d1", DW'({done1, done2}), DW'(2'b10));
    req1 = 1'b0;
    tick();
    chk("t2_idle", DW'({gnt1, gnt2, busy}), '0);
    tick();
    chk("t2_g2", DW'({gnt1, gnt2}), DW'(2'b01));
    tick();
    tick();
    chk("t2_d2", DW'({done1, done2}), DW'(2'b01));
    req2 = 1'b0;
    tick();

    // 3: both held, grants alternate every 4 cycles
    do_reset();
    srdata = 64'h3333;
    req1 = 1'b1;
    req2 = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk($sformatf("t3_gnt_c%0d", k), DW'({gnt1, gnt2}),
          DW'({k % 8 == 1, k % 8 == 5}));
    end
    req1 = 1'b0;
    req2 = 1'b0;
    tick();
    chk("t3_quiet", DW'({gnt1, gnt2, busy}), '0);

    // 4: requester 2 write
    req2 = 1'b1;
    wr2 = 1'b1;
    addr2 = 19'h7FFFF;
    wdata2 = {8{8'hA5}};
    srdata = 64'hDEAD;
    tick();
    req2 = 1'b0;
    wr2 = 1'b0;
    addr2 = '0;
    wdata2 = '0;
    chk("t4_g2", DW'({gnt1, gnt2, ren, wen}), DW'(4'b0101));
    chk("t4_addr", DW'(saddr), DW'(19'h7FFFF));
    chk("t4_wdata", swdata, {8{8'hA5}});
    tick();
    chk("t4_acc2", DW'({ren, wen}), DW'(2'b01));
    tick();
    chk("t4_done", DW'({done1, done2, ren, wen}), DW'(4'b0100));
    chk("t4_rdata", rdata, 64'h3333);
    tick();
    chk("t4_once", DW'({done2, busy}), '0);
    chk("t4_hold_addr", DW'(saddr), DW'(19'h7FFFF));

    // 5: reset during second access cycle of a read
    req1 = 1'b1;
    addr1 = 19'h00ABC;
    tick();
    req1 = 1'b0;
    tick();
    chk("t5_acc2", DW'(ren), DW'(1'b1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_outs", DW'({gnt1, gnt2, done1, done2, busy, ren, wen}), '0);
    chk("t5_addr", DW'(saddr), '0);
    chk("t5_rdata", rdata, '0);
    req1 = 1'b1;
    req2 = 1'b1;
    tick();
    chk("t5_first", DW'({gnt1, gnt2, done1}), DW'(3'b100));
    req1 = 1'b0;
    req2 = 1'b0;
    tick();
    tick();
    tick();

    // 6: short req1 pulse while requester 2 is served
    req2 = 1'b1;
    tick();
    chk("t6_g2", DW'(gnt2), DW'(1'b1));
    req2 = 1'b0;
    req1 = 1'b1;
    tick();
    req1 = 1'b0;
    g1_seen = 0;
    d2_seen = 0;
    for (int k = 0; k < 6; k++) begin
      g1_seen += int'(gnt1) + int'(done1);
      d2_seen += int'(done2);
      tick();
    end
    chk("t6_no_g1", DW'(g1_seen), '0);
    chk("t6_d2", DW'(d2_seen), DW'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
